// File: rtl/sobel_stream_filter_pkg.sv
// Shared constants, window tap naming and gradient helpers for the Sobel stream filter.
package sobel_pkg;

  localparam int MAX_PIX_W = 16;
  localparam int MAX_MAG_W = MAX_PIX_W + 3;

  // 3x3 window template: taps are row-major, P0 top-left, P8 the newest pixel.
  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  typedef enum logic [3:0] {
    P0 = 4'd0, P1 = 4'd1, P2 = 4'd2,
    P3 = 4'd3, P4 = 4'd4, P5 = 4'd5,
    P6 = 4'd6, P7 = 4'd7, P8 = 4'd8
  } tap_e;

  // Signed width that holds gx or gy without overflow for a pix_w-bit pixel.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  // True when the magnitude exceeds 2^pix_w-1 and must be clamped.
  function automatic logic mag_saturates(input logic [MAX_MAG_W-1:0] mag, input int pix_w);
    logic over;
    over = 1'b0;
    for (int i = 0; i < MAX_MAG_W; i++) begin
      if (i >= pix_w && mag[i]) over = 1'b1;
    end
    return over;
  endfunction

endpackage

// File: rtl/sobel_stream_filter_if.sv
// Valid/ready pixel stream bundle used around the Sobel filter.
interface sobel_stream_filter_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage: combinational read and write at the same
// address, so a read returns the value stored one line earlier.
module sobel_line_buffer #(
  parameter  int PIX_W = 8,
  parameter  int DEPTH = 640,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // NOTE: storage arrays carry no reset so they map onto RAM; whatever they
  // hold at power-up is overwritten before any output depends on it.
  always_ff @(posedge clk_i) begin
    if (en) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge-magnitude filter, two pipeline stages, valid/ready both sides.
// Build option: define SOBEL_THRESHOLD_EN to add thresh_i and binarise the output.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [PIX_W-1:0] pixel_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [PIX_W-1:0] pixel_o,
  output logic             last_o
`ifdef SOBEL_THRESHOLD_EN
  ,
  input  logic [PIX_W-1:0] thresh_i
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = grad_w(PIX_W);

  typedef logic signed [GW-1:0] grad_t;

  logic          en;
  logic          accept;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;
  logic          centre_ok;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign accept  = valid_i && en;

  assign col_end   = (col == CW'(IMG_W - 1));
  assign row_end   = (row == RW'(IMG_H - 1));
  assign centre_ok = (row >= RW'(2)) && (col >= CW'(2));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Two chained lines: line1 holds row-1, line2 holds row-2 at the same column.
  logic [PIX_W-1:0] line1_q;
  logic [PIX_W-1:0] line2_q;

  sobel_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line1 (
    .clk_i (clk_i),
    .en    (accept),
    .addr  (col),
    .wdata (pixel_i),
    .rdata (line1_q)
  );

  sobel_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line2 (
    .clk_i (clk_i),
    .en    (accept),
    .addr  (col),
    .wdata (line1_q),
    .rdata (line2_q)
  );

  // Stage 1: window register plus its control bits.
  logic [PIX_W-1:0] win [WIN_TAPS];
  logic             s1_valid;
  logic             s1_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept && centre_ok;
      s1_last  <= accept && row_end && col_end;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      win[P0] <= win[P1];
      win[P1] <= win[P2];
      win[P2] <= line2_q;
      win[P3] <= win[P4];
      win[P4] <= win[P5];
      win[P5] <= line1_q;
      win[P6] <= win[P7];
      win[P7] <= win[P8];
      win[P8] <= pixel_i;
    end
  end

  function automatic grad_t ext(input logic [PIX_W-1:0] p);
    return grad_t'({3'b000, p});
  endfunction

  grad_t            gx;
  grad_t            gy;
  logic [GW-1:0]    abs_gx;
  logic [GW-1:0]    abs_gy;
  logic [GW-1:0]    mag;
  logic [PIX_W-1:0] sat;
  logic [PIX_W-1:0] result;

  // NOTE: every always_comb output gets a value on every path (here the
  // defaults come first), otherwise synthesis infers a latch.
  always_comb begin
    result = '0;
    gx = (ext(win[P2]) - ext(win[P0]))
       + ((ext(win[P5]) - ext(win[P3])) <<< 1)
       + (ext(win[P8]) - ext(win[P6]));
    gy = (ext(win[P0]) - ext(win[P6]))
       + ((ext(win[P1]) - ext(win[P7])) <<< 1)
       + (ext(win[P2]) - ext(win[P8]));
    abs_gx = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    // Each |g| is below 2^(PIX_W+2), so the sum cannot wrap in GW bits.
    mag = abs_gx + abs_gy;
    sat = mag_saturates(MAX_MAG_W'(mag), PIX_W) ? '1 : mag[PIX_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
    result = (sat > thresh_i) ? '1 : '0;
`else
    result = sat;
`endif
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      pixel_o <= '0;
    end else if (en) begin
      valid_o <= s1_valid;
      last_o  <= s1_last;
      pixel_o <= result;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter on a 4x4 frame with randomized
// stimulus against a direct convolution model.
`timescale 1ns/1ps
module tb_sobel_stream_filter;

  localparam int PW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  typedef logic [PW-1:0] frame_t [NPIX];
  typedef struct {
    logic [PW-1:0] val;
    logic          last;
    int            cyc;
    int            acc;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sobel_stream_filter_if #(.DATA_W(PW)) in_if ();
  sobel_stream_filter_if #(.DATA_W(PW)) out_if ();
`ifdef SOBEL_THRESHOLD_EN
  logic [PW-1:0] thresh;
`endif

  sobel_stream_filter #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (in_if.valid),
    .ready_o (in_if.ready),
    .pixel_i (in_if.data),
    .valid_o (out_if.valid),
    .ready_i (out_if.ready),
    .pixel_o (out_if.data),
    .last_o  (out_if.last)
`ifdef SOBEL_THRESHOLD_EN
    ,
    .thresh_i(thresh)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   acc_cyc [$];
  out_t got_q [$];
  out_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records each transfer that will complete at the coming rising edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_if.valid && out_if.ready)
      got_q.push_back('{val: out_if.data, last: out_if.last, cyc: cyc, acc: n_acc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: direct 3x3 Sobel over each interior pixel of a frame.
  function automatic void model_frame(input frame_t img);
    int p [9];
    int gx, gy, mag;
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            p[i*3+j] = int'(img[(r-2+i)*W + (c-2+j)]);
        gx  = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
        gy  = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
        mag = (mag > int'(thresh)) ? 255 : 0;
`endif
        exp_q.push_back('{val: PW'(mag), last: (r == H-1 && c == W-1), cyc: 0, acc: 0});
      end
    end
  endfunction

  task automatic push(input logic [PW-1:0] p);
    int guard = 0;
    @(negedge clk);
    in_if.valid = 1'b1;
    in_if.data  = p;
    #1;
    while (!in_if.ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: ready_o stayed 0, required 1");
    end
    acc_cyc.push_back(cyc);
    @(posedge clk);
    n_acc++;
  endtask

  task automatic idle();
    @(negedge clk);
    in_if.valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t img);
    for (int i = 0; i < NPIX; i++) push(img[i]);
  endtask

  task automatic drain();
    int g = 0;
    while (got_q.size() < exp_q.size() && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic start_test();
    got_q.delete(); exp_q.delete(); acc_cyc.delete();
    n_acc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_if.valid); end
    n_checks++; if (out_if.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b, required 0", out_if.last); end
    n_checks++; if (out_if.data !== '0) begin n_fail++; $display("FAIL reset_pixel: got %0d, required 0", out_if.data); end
    n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", in_if.ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    frame_t f;
    start_test();
    foreach (f[i]) f[i] = 8'd100;
    model_frame(f);
    send_frame(f); idle(); drain();
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL const_count: got %0d outputs, required 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL const_val[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val); end
      n_checks++; if (got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL const_last[%0d]: got %b, required %b", i, got_q[i].last, exp_q[i].last); end
    end
  endtask

  task automatic test_ramp();
    frame_t f;
    start_test();
    foreach (f[i]) f[i] = PW'((i % W) * 10);
    model_frame(f);
    send_frame(f); idle(); drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ramp_count: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL ramp_val[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val); end
      n_checks++; if (got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL ramp_last[%0d]: got %b, required %b", i, got_q[i].last, exp_q[i].last); end
    end
    if (got_q.size() > 0 && acc_cyc.size() > 10) begin
      n_checks++;
      if (got_q[0].cyc - acc_cyc[10] != 2) begin
        n_fail++; $display("FAIL ramp_latency: got %0d cycles, required 2", got_q[0].cyc - acc_cyc[10]);
      end
    end
  endtask

  task automatic test_saturate();
    frame_t f;
    start_test();
    foreach (f[i]) f[i] = ((i % W) < 2) ? 8'd0 : 8'd255;
    model_frame(f);
    send_frame(f); idle(); drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_count: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL sat_val[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val); end
      n_checks++; if (got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL sat_last[%0d]: got %b, required %b", i, got_q[i].last, exp_q[i].last); end
    end
  endtask

  task automatic test_backpressure();
    frame_t        f;
    logic [PW-1:0] held;
    logic          held_last;
    start_test();
    foreach (f[i]) f[i] = PW'($urandom_range(0, 255));
    model_frame(f);
    fork
      begin
        send_frame(f);
        idle();
      end
      begin
        int guard = 0;
        while (guard < 200) begin
          @(negedge clk);
          if (out_if.valid) break;
          guard++;
        end
        if (guard >= 200) begin
          n_checks++; n_fail++;
          $display("FAIL bp_wait: valid_o stayed 0, required 1");
        end else begin
          out_if.ready = 1'b0;
          #2;
          held      = out_if.data;
          held_last = out_if.last;
          for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #2; end
            n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b, required 1", k, out_if.valid); end
            n_checks++; if (out_if.data !== held) begin n_fail++; $display("FAIL bp_pixel[%0d]: got %0d, required %0d", k, out_if.data, held); end
            n_checks++; if (out_if.last !== held_last) begin n_fail++; $display("FAIL bp_last[%0d]: got %b, required %b", k, out_if.last, held_last); end
            n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b, required 0", k, in_if.ready); end
          end
          @(negedge clk);
          out_if.ready = 1'b1;
        end
      end
    join
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL bp_val[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val); end
      n_checks++; if (got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL bp_last_seq[%0d]: got %b, required %b", i, got_q[i].last, exp_q[i].last); end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f [3];
    bit     done;
    start_test();
    done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      foreach (f[n][i]) f[n][i] = PW'($urandom_range(0, 255));
      model_frame(f[n]);
    end
    fork
      begin
        for (int n = 0; n < 3; n++) send_frame(f[n]);
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_if.ready = ($urandom_range(0, 3) != 0);
        end
        out_if.ready = 1'b1;
      end
    join
    drain();
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL b2b_val[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val); end
      n_checks++; if (got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b, required %b", i, got_q[i].last, exp_q[i].last); end
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    start_test();
    for (int i = 0; i < 7; i++) push(PW'($urandom_range(0, 255)));
    #3;
    rst_n       = 1'b0;
    in_if.valid = 1'b0;
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rst_partial: got %0d outputs, required 0", got_q.size()); end
    @(negedge clk);
    #1;
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", out_if.valid); end
    @(negedge clk);
    rst_n = 1'b1;
    start_test();
    foreach (f[i]) f[i] = 8'd50;
    model_frame(f);
    send_frame(f); idle(); drain();
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL rst_count: got %0d outputs, required 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i].val !== exp_q[i].val) begin n_fail++; $display("FAIL rst_val[%0d]: got %0d, required %0d", i, got_q[i].val, exp_q[i].val); end
      n_checks++; if (got_q[i].last !== exp_q[i].last) begin n_fail++; $display("FAIL rst_last[%0d]: got %b, required %b", i, got_q[i].last, exp_q[i].last); end
    end
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0].acc < 11) begin n_fail++; $display("FAIL rst_first_out: after %0d accepted pixels, required at least 11", got_q[0].acc); end
    end
  endtask

`ifdef SOBEL_THRESHOLD_EN
  task automatic test_threshold();
    frame_t        f;
    logic [PW-1:0] want;
    foreach (f[i]) f[i] = PW'((i % W) * 10);
    for (int t = 0; t < 2; t++) begin
      start_test();
      thresh = (t == 0) ? 8'd79 : 8'd80;
      want   = (t == 0) ? 8'd255 : 8'd0;
      send_frame(f); idle();
      repeat (12) @(negedge clk);
      n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL thr_count[%0d]: got %0d outputs, required 4", thresh, got_q.size()); end
      for (int i = 0; i < got_q.size(); i++) begin
        n_checks++; if (got_q[i].val !== want) begin n_fail++; $display("FAIL thr_val[%0d][%0d]: got %0d, required %0d", thresh, i, got_q[i].val, want); end
      end
    end
    thresh = 8'd0;
  endtask
`endif

  initial begin
    rst_n        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;
`ifdef SOBEL_THRESHOLD_EN
    thresh       = 8'd0;
`endif
    test_reset();
    test_constant();
    test_ramp();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
`ifdef SOBEL_THRESHOLD_EN
    test_threshold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
